sha256_round_engine: RTL

// - Parametrised SHA-256/224 compression engine: iterates NUM_ROUNDS rounds, ROUNDS_PER_CYCLE unrolled per clock.
// - Per-round K/W words arrive on a valid/ready stream; feed-forward and multi-block chaining are internal.
// - Digest leaves on a valid/ready port. Sits between the message-schedule unit and the digest/host interface.

---
 rtl/sha256_round_engine.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/sha256_round_engine.sv
// -----------------------------------------------------------------------------
// sha256_round_engine
//
// SHA-256 compression engine. It runs NUM_ROUNDS rounds per block and unrolls
// ROUNDS_PER_CYCLE rounds into each accepted K/W beat. The feed-forward add and
// multi-block chaining are held inside the engine, so the message-schedule unit
// only streams K/W words and the host only collects digests.
//
// Optional build macro: SHA256_ENGINE_SHA224_EN
//   When defined, the engine gains a mode224_i input. That input is sampled
//   together with start_i && first_i. Mode 1 seeds the SHA-224 IV and zeroes
//   digest_o[31:0]. The chain registers still keep the full H7 word, and the
//   mode is kept for chained blocks.
//
// Parameters
//   ROUNDS_PER_CYCLE  rounds applied per beat (1, 2 or 4; divides NUM_ROUNDS)
//   NUM_ROUNDS        rounds per block (64 for standard SHA-2)
//
// Ports
//   clk             clock, rising edge
//   rst_n           asynchronous active-low reset
//   start_i         start a block (sampled only when idle)
//   first_i         1 = seed from IV, 0 = chain from previous digest
//   mode224_i       (SHA224 build only) select the SHA-224 IV and truncation
//   w_valid_i       K/W beat valid
//   w_ready_o       engine accepts a beat (only while running rounds)
//   w_i, k_i        per-round W/K words, lane 0 = earliest round
//   digest_valid_o  digest_o holds a finished digest
//   digest_ready_i  consumer takes the digest
//   digest_o        {H0..H7}, H0 in the top word
//   busy_o          engine is not idle
//   round_o         rounds completed in the current block
// -----------------------------------------------------------------------------
module sha256_round_engine #(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int NUM_ROUNDS       = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start_i,
    input  logic                           first_i,
`ifdef SHA256_ENGINE_SHA224_EN
    input  logic                           mode224_i,
`endif
    input  logic                           w_valid_i,
    output logic                           w_ready_o,
    input  logic [32*ROUNDS_PER_CYCLE-1:0] w_i,
    input  logic [32*ROUNDS_PER_CYCLE-1:0] k_i,
    output logic                           digest_valid_o,
    input  logic                           digest_ready_i,
    output logic [255:0]                   digest_o,
    output logic                           busy_o,
    output logic [6:0]                     round_o
);

    localparam logic [255:0] IV256 =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
`ifdef SHA256_ENGINE_SHA224_EN
    localparam logic [255:0] IV224 =
        256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
`endif
    localparam logic [6:0] RPC7 = 7'(ROUNDS_PER_CYCLE);
    localparam logic [6:0] NR7  = 7'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_FINAL,
        ST_OUT
    } state_t;

    state_t        state_reg;
    state_t        state_next;

    // Working variables packed as {a,b,c,d,e,f,g,h}; a is the top word.
    logic [255:0]  work_reg;
    logic [255:0]  base_reg;
    logic [255:0]  chain_reg;
    logic [255:0]  digest_reg;
    logic [6:0]    round_reg;
    logic [6:0]    round_next;
`ifdef SHA256_ENGINE_SHA224_EN
    logic          mode224_reg;
`endif

    logic          beat_fire;
    logic [255:0]  init_sel;
    logic [255:0]  digest_sum;
    logic [255:0]  final_digest;
    logic [255:0]  stage [0:ROUNDS_PER_CYCLE];

    // ------------------------------------------------------------------
    // SHA-256 round primitives. A right rotate by n is {x[n-1:0], x[31:n]}.
    // ------------------------------------------------------------------
    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    // ------------------------------------------------------------------
    // Unrolled round chain. Lane gi consumes K/W lane gi, so lane 0 is the
    // earliest round of the beat.
    // ------------------------------------------------------------------
    assign stage[0] = work_reg;

    genvar gi;
    generate
        for (gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_round
            logic [31:0] a_w, b_w, c_w, d_w, e_w, f_w, g_w, h_w;
            logic [31:0] t1_w, t2_w;
            assign {a_w, b_w, c_w, d_w, e_w, f_w, g_w, h_w} = stage[gi];
            assign t1_w = h_w + bsig1(e_w) + ch(e_w, f_w, g_w)
                        + k_i[32*gi +: 32] + w_i[32*gi +: 32];
            assign t2_w = bsig0(a_w) + maj(a_w, b_w, c_w);
            assign stage[gi+1] = {t1_w + t2_w, a_w, b_w, c_w,
                                  d_w + t1_w,  e_w, f_w, g_w};
        end
    endgenerate

    // Feed-forward: each word wraps on its own, and no carry crosses words.
    generate
        for (gi = 0; gi < 8; gi++) begin : g_ffwd
            assign digest_sum[32*gi +: 32] = base_reg[32*gi +: 32] + work_reg[32*gi +: 32];
        end
    endgenerate

    // Seed for a new block: the IV for a first block, otherwise the last digest.
    always_comb begin
        init_sel = chain_reg;
        if (first_i) begin
            init_sel = IV256;
`ifdef SHA256_ENGINE_SHA224_EN
            if (mode224_i) begin
                init_sel = IV224;
            end
`endif
        end
    end

    always_comb begin
        final_digest = digest_sum;
`ifdef SHA256_ENGINE_SHA224_EN
        if (mode224_reg) begin
            final_digest[31:0] = 32'h0;
        end
`endif
    end

    assign beat_fire  = (state_reg == ST_ROUND) && w_valid_i;
    assign round_next = round_reg + RPC7;

    // ------------------------------------------------------------------
    // FSM: state register and next-state logic.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    state_next = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (w_valid_i && (round_next == NR7)) begin
                    state_next = ST_FINAL;
                end
            end
            ST_FINAL: begin
                state_next = ST_OUT;
            end
            ST_OUT: begin
                if (digest_ready_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers. Reset also returns the chain to the IV, so a
    // block aborted by reset never leaks into the next chained start.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_reg    <= '0;
            base_reg    <= '0;
            chain_reg   <= IV256;
            digest_reg  <= '0;
            round_reg   <= '0;
`ifdef SHA256_ENGINE_SHA224_EN
            mode224_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_i) begin
                        work_reg  <= init_sel;
                        base_reg  <= init_sel;
                        round_reg <= '0;
`ifdef SHA256_ENGINE_SHA224_EN
                        if (first_i) begin
                            mode224_reg <= mode224_i;
                        end
`endif
                    end
                end
                ST_ROUND: begin
                    if (beat_fire) begin
                        work_reg  <= stage[ROUNDS_PER_CYCLE];
                        round_reg <= round_next;
                    end
                end
                ST_FINAL: begin
                    digest_reg <= final_digest;
                    chain_reg  <= digest_sum;
                end
                default: begin
                end
            endcase
        end
    end

    assign w_ready_o      = (state_reg == ST_ROUND);
    assign digest_valid_o = (state_reg == ST_OUT);
    assign busy_o         = (state_reg != ST_IDLE);
    assign round_o        = round_reg;
    assign digest_o       = digest_reg;

endmodule
